cdc_a2s_rx_arbiter: RTL and testbench
=====================================

Name: cdc_a2s_rx_arbiter

Overview:
Synchronous-side receive controller for NCH asynchronous-to-synchronous CDC channels. Each channel presents bundled data Din with a four-phase Si/So handshake. The block synchronizes each Si, arbitrates round-robin among pending channels, and captures one word per cycle into a single valid/ready output register. It completes each channel's four-phase handshake, so the async TX side sees a standard return-to-zero acknowledge.

Parameters:
NCH, 4, number of CDC channels (1..16)
DW, 64, data width per channel
SYNC_STAGES, 2, flops in each Si synchronizer (>=2)
CW (localparam), max(1,clog2(NCH)), channel-index width

Ports:
CLK  input  1  sole clock, rising-edge
RESET  input  1  asynchronous, active-low reset
Si  input  NCH  per-channel request from async side; Din stable while Si=1 and So=0
Din  input  NCH*DW  packed channel data; channel k at [k*DW +: DW]
So  output  NCH  per-channel acknowledge to async side
Dout  output  DW  captured word
DoutCh  output  CW  source channel of Dout
DoutValid  output  1  Dout holds an unconsumed word
DoutReady  input  1  downstream accepts Dout when DoutValid=1
RxCount  output  32  total words captured, wraps at 2^32

Behaviour:
- Reset (RESET=0, asynchronous): So=0, Dout=0, DoutCh=0, DoutValid=0, RxCount=0, sync flops=0, round-robin pointer=0.
- Synchronizer: Ssync[k] is Si[k] after SYNC_STAGES flops. Only Ssync is used internally, never raw Si.
- Per-channel states, encoded by So[k]:
  - IDLE (So=0): pending when Ssync=1.
  - ACK (So=1): stay until Ssync=0, then clear So on the next edge and return to IDLE.
- Capture slot is free when DoutValid=0 or DoutValid&DoutReady.
- Arbitration, once per cycle while the capture slot is free:
  - Grant the first pending channel searching from ptr upward, mod NCH.
  - On the grant edge, all at once: Dout<=Din[g], DoutCh<=g, DoutValid<=1, So[g]<=1, RxCount+=1, ptr<=(g+1) mod NCH.
  - At most one grant per cycle.
- DoutValid clears on DoutValid&DoutReady only when there is no grant in the same cycle. Consume and grant in the same cycle: new word loaded, DoutValid stays 1 with no bubble.
- Backpressure: while the slot is not free, no grant is issued. Pending channels keep So=0, so the async side holds Si and Din.
- Latency, uncontested with a free slot:
  - So rises at the (SYNC_STAGES+1)th rising edge after Si rises, and Dout is valid on the same edge.
  - So falls at the (SYNC_STAGES+1)th edge after Si falls.
  - Minimum period per channel is 2*(SYNC_STAGES+1) cycles plus async delay.
- Pending but never granted before Ssync drops (protocol violation): the request is silently dropped. No capture, So stays 0.
- Ptr advances only on a grant. Idle cycles do not move it.
- Reset mid-handshake: So drops immediately and any held word is lost. After release, a channel whose Si is still 1 is treated as a fresh request and captured again. The async side must be reset together with this block.
- NCH=1: ptr is constant 0 and DoutCh=0.

Test Plan:
1. NCH=4, SYNC_STAGES=2, DoutReady=1; Si[0] rises with Din[0]=64'hDEADBEEF00000001 -> So[0]=1 on edge 3 with Dout=that value, DoutCh=0, DoutValid=1 for exactly 1 cycle; Si[0] falls -> So[0]=0 on edge 3 after; RxCount=1.
2. Si[3:0] rise together, distinct Din, DoutReady=1 -> grants ch0,1,2,3 on 4 consecutive edges, DoutValid continuously 1 for 4 cycles, RxCount=4, ptr=0.
3. DoutReady=0; Si[1],Si[2] high -> ch1 captured, So[1]=1; So[2] stays 0 for 10 cycles; raise DoutReady for 1 cycle -> same edge loads ch2 data, DoutValid stays 1, So[2]=1.
4. Ch0 and ch3 each re-request immediately after completing their handshakes, 8 words total -> DoutCh sequence 0,3,0,3,0,3,0,3; neither is starved.
5. So[2]=1 mid-handshake, RESET pulsed low -> So=0, DoutValid=0, RxCount=0 without waiting for a CLK edge; release with Si[2]=1 held -> ch2 captured again after SYNC_STAGES+1 edges.
6. 16 tokens per channel, random DoutReady (50%) and random Si delays -> RxCount=64; every Din word is seen exactly once on Dout with the correct DoutCh; per-channel order is preserved.

Source files
------------

// File: rtl/cdc_a2s_rx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_a2s_rx_arbiter_if
// Brief    : Async-side channel handshake and sync-side valid/ready bundle.
// Revision : 1.0
// ============================================================================
interface cdc_a2s_rx_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 64,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]    Si;
    logic [NCH*DW-1:0] Din;
    logic [NCH-1:0]    So;
    logic [DW-1:0]     Dout;
    logic [CW-1:0]     DoutCh;
    logic              DoutValid;
    logic              DoutReady;
    logic [31:0]       RxCount;

    modport master (
        output Si, Din, DoutReady,
        input  So, Dout, DoutCh, DoutValid, RxCount
    );

    modport slave (
        input  Si, Din, DoutReady,
        output So, Dout, DoutCh, DoutValid, RxCount
    );
endinterface
`default_nettype wire

// File: rtl/cdc_a2s_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_a2s_rx_arbiter
// Brief    : Synchronizes NCH four-phase CDC requests, round-robin captures one
//            word per cycle into a valid/ready register and acknowledges it.
// Revision : 1.0
// ============================================================================
module cdc_a2s_rx_arbiter #(
    parameter int NCH         = 4,
    parameter int DW          = 64,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    cdc_a2s_rx_arbiter_if.slave   bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] sync_d [SYNC_STAGES];
    logic [NCH-1:0] so_q, so_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic [CW-1:0]  dout_ch_q, dout_ch_d;
    logic           valid_q, valid_d;
    logic [31:0]    rx_count_q, rx_count_d;
    logic [CW-1:0]  ptr_q, ptr_d;

    logic [NCH-1:0] ssync;
    logic [NCH-1:0] pending;
    logic           slot_free;
    logic           grant;
    logic [CW-1:0]  gnt_idx;
    logic [CW-1:0]  cand_idx;

    assign ssync     = sync_q[SYNC_STAGES-1];
    assign pending   = ssync & ~so_q;
    assign slot_free = ~valid_q | bus.DoutReady;

    always_comb begin
        sync_d[0] = bus.Si;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // First pending channel at or above ptr, wrapping modulo NCH.
    always_comb begin
        grant    = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            cand_idx = CW'((int'(ptr_q) + i) % NCH);
            if (!grant && slot_free && pending[cand_idx]) begin
                grant   = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    always_comb begin
        so_d       = so_q & ssync;
        dout_d     = dout_q;
        dout_ch_d  = dout_ch_q;
        ptr_d      = ptr_q;
        rx_count_d = rx_count_q + 32'(grant);
        valid_d    = (valid_q && bus.DoutReady) ? 1'b0 : valid_q;
        if (grant) begin
            so_d[gnt_idx] = 1'b1;
            dout_ch_d     = gnt_idx;
            ptr_d         = CW'((int'(gnt_idx) + 1) % NCH);
            valid_d       = 1'b1;
        end
        for (int k = 0; k < NCH; k++) begin
            if (grant && gnt_idx == CW'(k)) begin
                dout_d = bus.Din[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            so_q       <= '0;
            dout_q     <= '0;
            dout_ch_q  <= '0;
            valid_q    <= 1'b0;
            rx_count_q <= '0;
            ptr_q      <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            so_q       <= so_d;
            dout_q     <= dout_d;
            dout_ch_q  <= dout_ch_d;
            valid_q    <= valid_d;
            rx_count_q <= rx_count_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.So        = so_q;
    assign bus.Dout      = dout_q;
    assign bus.DoutCh    = dout_ch_q;
    assign bus.DoutValid = valid_q;
    assign bus.RxCount   = rx_count_q;
endmodule
`default_nettype wire

// File: tb/tb_cdc_a2s_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_a2s_rx_arbiter
// Brief    : Directed latency/arbitration/reset scenarios plus randomized
//            multi-channel traffic against a per-channel scoreboard.
// Revision : 1.0
// ============================================================================
module tb_cdc_a2s_rx_arbiter;
    localparam int NCH = 4;
    localparam int DW  = 64;
    localparam int CW  = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    si_r  = '0;
    logic [NCH*DW-1:0] din_r = '0;
    logic              rdy   = 1'b1;
    bit                done  = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [63:0]   exp_q [NCH][$];
    logic [CW-1:0] log_ch[$];
    logic [63:0]   log_d[$];

    cdc_a2s_rx_arbiter_if #(.NCH(NCH), .DW(DW)) bus ();

    assign bus.Si        = si_r;
    assign bus.Din       = din_r;
    assign bus.DoutReady = rdy;

    cdc_a2s_rx_arbiter #(.NCH(NCH), .DW(DW), .SYNC_STAGES(2)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Every word handed downstream, in consumption order.
    always @(negedge clk) begin
        if (rst_n && bus.DoutValid && bus.DoutReady) begin
            log_ch.push_back(bus.DoutCh);
            log_d.push_back(bus.Dout);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        si_r  = '0;
        din_r = '0;
        rdy   = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // One four-phase transfer as the async transmitter would perform it.
    task automatic tx_word(input int ch, input logic [63:0] d);
        int n;
        din_r[ch*DW +: DW] = d;
        si_r[ch] = 1'b1;
        exp_q[ch].push_back(d);
        n = 0;
        do begin tick(1); n++; end while (bus.So[ch] !== 1'b1 && n < 500);
        if (bus.So[ch] !== 1'b1) check("so_rise_timeout", 64'(bus.So[ch]), 64'd1);
        si_r[ch] = 1'b0;
        n = 0;
        do begin tick(1); n++; end while (bus.So[ch] !== 1'b0 && n < 500);
        if (bus.So[ch] !== 1'b0) check("so_fall_timeout", 64'(bus.So[ch]), 64'd0);
    endtask

    task automatic send_tokens(input int ch, input int cnt);
        for (int t = 0; t < cnt; t++) begin
            repeat ($urandom_range(0, 4)) tick(1);
            tx_word(ch, {$urandom, $urandom});
        end
    endtask

    initial begin
        logic [63:0] d1, d2, d;
        int c;

        // Reset state
        tick(1);
        check("rst_so",    64'(bus.So), 64'd0);
        check("rst_dout",  bus.Dout, 64'd0);
        check("rst_ch",    64'(bus.DoutCh), 64'd0);
        check("rst_valid", 64'(bus.DoutValid), 64'd0);
        check("rst_cnt",   64'(bus.RxCount), 64'd0);
        rst_n = 1'b1;

        // Single uncontested transfer: SYNC_STAGES+1 edges each way
        din_r[0 +: DW] = 64'hDEADBEEF00000001;
        si_r[0] = 1'b1;
        tick(1); check("t1_so_e1", 64'(bus.So), 64'd0);
        tick(1); check("t1_so_e2", 64'(bus.So), 64'd0);
        tick(1);
        check("t1_so_e3",  64'(bus.So), 64'h1);
        check("t1_dout",   bus.Dout, 64'hDEADBEEF00000001);
        check("t1_ch",     64'(bus.DoutCh), 64'd0);
        check("t1_valid",  64'(bus.DoutValid), 64'd1);
        check("t1_cnt",    64'(bus.RxCount), 64'd1);
        si_r[0] = 1'b0;
        tick(1);
        check("t1_valid_1cyc", 64'(bus.DoutValid), 64'd0);
        check("t1_so_hold1",   64'(bus.So), 64'h1);
        tick(1); check("t1_so_hold2", 64'(bus.So), 64'h1);
        tick(1); check("t1_so_fall",  64'(bus.So), 64'h0);

        // All four together: one grant per edge, no bubbles
        do_reset();
        for (int k = 0; k < NCH; k++) din_r[k*DW +: DW] = {32'hC0DE0000, 32'(k)};
        si_r = '1;
        tick(2);
        check("t2_so_early", 64'(bus.So), 64'd0);
        for (int k = 0; k < NCH; k++) begin
            tick(1);
            check("t2_ch",    64'(bus.DoutCh), 64'(k));
            check("t2_dout",  bus.Dout, {32'hC0DE0000, 32'(k)});
            check("t2_valid", 64'(bus.DoutValid), 64'd1);
        end
        si_r = '0;
        tick(1); check("t2_valid_end", 64'(bus.DoutValid), 64'd0);
        tick(2);
        check("t2_so_fall", 64'(bus.So), 64'd0);
        check("t2_cnt",     64'(bus.RxCount), 64'd4);

        // ch0/ch3 back-to-back re-requests; pointer left at 0 so ch0 goes first
        log_ch.delete();
        log_d.delete();
        fork
            begin for (int i = 0; i < 4; i++) tx_word(0, 64'h0400 + 64'(i)); end
            begin for (int i = 0; i < 4; i++) tx_word(3, 64'h0700 + 64'(i)); end
        join
        tick(3);
        check("t4_words", 64'(log_ch.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_ch.size(); i++) begin
            check("t4_ch_seq",   64'(log_ch[i]), (i % 2 == 0) ? 64'd0 : 64'd3);
            check("t4_data_seq", log_d[i], (i % 2 == 0) ? 64'h0400 + 64'(i/2) : 64'h0700 + 64'(i/2));
        end

        // Backpressure holds the second requester off
        do_reset();
        rdy = 1'b0;
        d1 = 64'h1111_2222_3333_4444;
        d2 = 64'h5555_6666_7777_8888;
        din_r[1*DW +: DW] = d1;
        din_r[2*DW +: DW] = d2;
        si_r[1] = 1'b1;
        si_r[2] = 1'b1;
        tick(3);
        check("t3_so1",   64'(bus.So[1]), 64'd1);
        check("t3_so2",   64'(bus.So[2]), 64'd0);
        check("t3_ch1",   64'(bus.DoutCh), 64'd1);
        check("t3_dout1", bus.Dout, d1);
        si_r[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t3_so2_held", 64'(bus.So[2]), 64'd0);
        end
        check("t3_valid_held", 64'(bus.DoutValid), 64'd1);
        check("t3_dout_held",  bus.Dout, d1);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        check("t3_ch2",     64'(bus.DoutCh), 64'd2);
        check("t3_dout2",   bus.Dout, d2);
        check("t3_valid",   64'(bus.DoutValid), 64'd1);
        check("t3_so2_ack", 64'(bus.So[2]), 64'd1);
        check("t3_cnt",     64'(bus.RxCount), 64'd2);

        // Asynchronous reset mid-handshake, Si[2] still high
        #3 rst_n = 1'b0;
        #1;
        check("t5_so",    64'(bus.So), 64'd0);
        check("t5_valid", 64'(bus.DoutValid), 64'd0);
        check("t5_cnt",   64'(bus.RxCount), 64'd0);
        #2 rst_n = 1'b1;
        tick(1); check("t5_so_e1", 64'(bus.So[2]), 64'd0);
        tick(1); check("t5_so_e2", 64'(bus.So[2]), 64'd0);
        tick(1);
        check("t5_so_e3", 64'(bus.So[2]), 64'd1);
        check("t5_ch",    64'(bus.DoutCh), 64'd2);
        check("t5_dout",  bus.Dout, d2);
        check("t5_cnt2",  64'(bus.RxCount), 64'd1);
        si_r[2] = 1'b0;
        rdy = 1'b1;
        tick(5);

        // Random traffic, random backpressure, scoreboard per channel
        do_reset();
        for (int k = 0; k < NCH; k++) exp_q[k].delete();
        log_ch.delete();
        log_d.delete();
        done = 1'b0;
        fork
            begin
                fork
                    send_tokens(0, 16);
                    send_tokens(1, 16);
                    send_tokens(2, 16);
                    send_tokens(3, 16);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rdy = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rdy = 1'b1;
        tick(10);
        check("t6_cnt",   64'(bus.RxCount), 64'd64);
        check("t6_words", 64'(log_ch.size()), 64'd64);
        for (int i = 0; i < log_ch.size(); i++) begin
            c = int'(log_ch[i]);
            if (exp_q[c].size() == 0) begin
                check("t6_extra_word", log_d[i], 64'd0 - 64'd1);
            end else begin
                d = exp_q[c].pop_front();
                check("t6_data_order", log_d[i], d);
            end
        end
        for (int k = 0; k < NCH; k++) check("t6_leftover", 64'(exp_q[k].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
